// File: rtl/window_5x5_gen.sv
// window_5x5_gen: streaming 5x5 neighbourhood generator feeding the Gaussian stage.
// Four line memories plus a short column history assemble one registered window per in-frame pixel.
module window_5x5_gen #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWIDTH*25-1:0] out_window,
  output logic                 out_eof
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DWIDTH-1:0] line_mem [4][IMG_WIDTH];

  // Only the four most recent columns are stored; the fifth is always the live column_in.
  logic [DWIDTH-1:0] hist_q    [4][5];
  logic [DWIDTH-1:0] shift_next [5][5];
  logic [DWIDTH-1:0] column_in [5];

  logic                 in_fire;
  logic                 emit;
  logic                 last_pixel;
  logic [DWIDTH*25-1:0] window_next;

  assign in_ready   = !out_valid || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign emit       = (row >= RW'(4)) && (col >= CW'(4));
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      column_in[r] = line_mem[r][col];
    end
    column_in[4] = in_data;
  end

  // Column index 0 is the oldest column, row index 0 the oldest line.
  always_comb begin
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 5; r++) begin
        shift_next[c][r] = '0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 5; r++) begin
        shift_next[c][r] = hist_q[c][r];
      end
    end
    for (int r = 0; r < 5; r++) begin
      shift_next[4][r] = column_in[r];
    end
  end

  always_comb begin
    window_next = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        window_next[(r*5 + c)*DWIDTH +: DWIDTH] = shift_next[c][r];
      end
    end
  end

  // Line memories are deliberately unreset; no window is emitted before row 4 of a frame.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int r = 0; r < 3; r++) begin
        line_mem[r][col] <= line_mem[r+1][col];
      end
      line_mem[3][col] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_eof    <= 1'b0;
      out_window <= '0;
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 5; r++) begin
          hist_q[c][r] <= '0;
        end
      end
    end else begin
      if (in_fire) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 5; r++) begin
            hist_q[c][r] <= shift_next[c+1][r];
          end
        end

        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (emit) begin
          out_valid  <= 1'b1;
          out_window <= window_next;
          out_eof    <= last_pixel;
        end else begin
          out_valid <= 1'b0;
          out_eof   <= 1'b0;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Self-checking bench for window_5x5_gen on an 8x6 frame.
// A frame-buffer model predicts every window; a negedge monitor compares each transferred window.
module tb_window_5x5_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int WW = DW * 25;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_window;
  logic          out_eof;

  int checks   = 0;
  int failures = 0;

  logic [WW-1:0] exp_win [$];
  bit            exp_eof [$];
  logic [WW-1:0] got_win [$];
  bit            got_eof [$];
  logic [WW-1:0] model_log [$];
  logic [WW-1:0] ref_win [$];

  logic [DW-1:0] img [H][W];
  int            m_row = 0;
  int            m_col = 0;

  bit            stall_prev = 0;
  logic [WW-1:0] stall_win;
  bit            stall_eof;
  bit            rand_ready = 0;

  always #5 clock = ~clock;

  window_5x5_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DWIDTH    (DW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window),
    .out_eof   (out_eof)
  );

  task automatic check_output(string name, logic [WW-1:0] actual, logic [WW-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [DW-1:0] get_byte(logic [WW-1:0] w, int k);
    return w[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pattern(int kind, int r, int c);
    case (kind)
      0:       return DW'(r*16 + c);
      1:       return DW'(255 - r*16 - c);
      default: return DW'($urandom_range(255, 0));
    endcase
  endfunction

  // Reference: keep the whole frame and cut the 5x5 neighbourhood out of it directly.
  task automatic model_accept(logic [DW-1:0] d);
    logic [WW-1:0] w;
    img[m_row][m_col] = d;
    if (m_row >= 4 && m_col >= 4) begin
      w = '0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          w[(r*5 + c)*DW +: DW] = img[m_row-4+r][m_col-4+c];
      exp_win.push_back(w);
      exp_eof.push_back(m_row == H-1 && m_col == W-1);
      model_log.push_back(w);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end
  endtask

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    exp_win.delete();
    exp_eof.delete();
  endtask

  task automatic start_log();
    got_win.delete();
    got_eof.delete();
    model_log.delete();
  endtask

  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      check_output("in_ready_rule", WW'(in_ready), WW'(!out_valid || out_ready));
      if (out_valid && !out_ready) begin
        if (stall_prev) begin
          check_output("stall_window_hold", out_window, stall_win);
          check_output("stall_eof_hold", WW'(out_eof), WW'(stall_eof));
        end
        stall_prev = 1;
        stall_win  = out_window;
        stall_eof  = out_eof;
      end else begin
        stall_prev = 0;
      end
      if (out_valid && out_ready) begin
        got_win.push_back(out_window);
        got_eof.push_back(out_eof);
        if (exp_win.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_window actual=%0h required=none", out_window);
        end else begin
          check_output("window", out_window, exp_win.pop_front());
          check_output("eof", WW'(out_eof), WW'(exp_eof.pop_front()));
        end
      end
    end
  end

  task automatic send_pixel(logic [DW-1:0] d, bit gaps);
    bit acc;
    int budget;
    if (gaps && $urandom_range(1, 0) == 1) begin
      in_valid = 1'b0;
      if (rand_ready) out_ready = 1'($urandom_range(1, 0));
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    forever begin
      if (rand_ready) out_ready = 1'($urandom_range(1, 0));
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      if (acc) begin
        model_accept(d);
        break;
      end
      budget++;
      if (budget > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout actual=%0d required=<=200", budget);
        break;
      end
    end
  endtask

  task automatic stall_three(logic [DW-1:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_output("bp_in_ready", WW'(in_ready), WW'(0));
      check_output("bp_out_valid", WW'(out_valid), WW'(1));
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic apply_stimulus(int kind, bit gaps, int npix, bit bp);
    logic [DW-1:0] d;
    for (int i = 0; i < npix; i++) begin
      d = pattern(kind, (i / W) % H, i % W);
      if (bp && i == 4*W + 5) stall_three(d);
      send_pixel(d, gaps);
    end
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    rand_ready = 0;
    out_ready  = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_output("drained", WW'(exp_win.size()), WW'(0));
  endtask

  task automatic compare_ref(string name);
    check_output({name, "_count"}, WW'(got_win.size()), WW'(ref_win.size()));
    for (int i = 0; i < got_win.size() && i < ref_win.size(); i++)
      check_output($sformatf("%s_win%0d", name, i), got_win[i], ref_win[i]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int eof_count;

    repeat (2) @(posedge clock);
    #1;
    check_output("reset_in_ready", WW'(in_ready), WW'(1));
    check_output("reset_out_valid", WW'(out_valid), WW'(0));
    check_output("reset_out_eof", WW'(out_eof), WW'(0));
    check_output("reset_out_window", out_window, '0);
    reset = 1'b0;
    @(posedge clock); #1;

    $display("[TB] gapless frame");
    start_log();
    apply_stimulus(0, 0, W*H, 0);
    drain();
    check_output("a_count", WW'(got_win.size()), WW'(8));
    if (got_win.size() == 8) begin
      check_output("a_first_b0", WW'(get_byte(got_win[0], 0)), WW'(8'h00));
      check_output("a_first_b12", WW'(get_byte(got_win[0], 12)), WW'(8'h22));
      check_output("a_first_b24", WW'(get_byte(got_win[0], 24)), WW'(8'h44));
      check_output("a_last_b0", WW'(get_byte(got_win[7], 0)), WW'(8'h13));
      check_output("a_last_b24", WW'(get_byte(got_win[7], 24)), WW'(8'h57));
      check_output("a_last_eof", WW'(got_eof[7]), WW'(1));
      eof_count = 0;
      for (int i = 0; i < 8; i++) eof_count += int'(got_eof[i]);
      check_output("a_eof_count", WW'(eof_count), WW'(1));
    end
    ref_win = model_log;

    $display("[TB] backpressure frame");
    start_log();
    apply_stimulus(0, 0, W*H, 1);
    drain();
    compare_ref("bp");

    $display("[TB] gapped frame");
    start_log();
    apply_stimulus(0, 1, W*H, 0);
    drain();
    compare_ref("gap");

    $display("[TB] two back-to-back frames");
    start_log();
    apply_stimulus(0, 0, W*H, 0);
    apply_stimulus(1, 0, W*H, 0);
    drain();
    check_output("two_count", WW'(got_win.size()), WW'(16));
    if (got_win.size() == 16) begin
      check_output("f2_first_b0", WW'(get_byte(got_win[8], 0)), WW'(8'hFF));
      check_output("f2_first_b24", WW'(get_byte(got_win[8], 24)), WW'(8'hBB));
      check_output("f2_last_eof", WW'(got_eof[15]), WW'(1));
    end

    $display("[TB] reset with a window pending");
    start_log();
    apply_stimulus(0, 0, 4*W + 5, 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clock);
    check_output("pre_reset_valid", WW'(out_valid), WW'(1));
    #2;
    reset = 1'b1;
    #1;
    check_output("async_out_valid", WW'(out_valid), WW'(0));
    check_output("async_out_eof", WW'(out_eof), WW'(0));
    check_output("async_out_window", out_window, '0);
    check_output("async_in_ready", WW'(in_ready), WW'(1));
    model_reset();
    @(posedge clock); #1;
    reset     = 1'b0;
    out_ready = 1'b1;

    $display("[TB] reset after 20 pixels");
    apply_stimulus(0, 0, 20, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    start_log();
    apply_stimulus(0, 0, W*H, 0);
    drain();
    compare_ref("rst20");

    $display("[TB] random pixels with gaps and random out_ready");
    start_log();
    rand_ready = 1;
    apply_stimulus(2, 1, W*H, 0);
    drain();
    check_output("rand_count", WW'(got_win.size()), WW'(8));
    if (got_win.size() == 8)
      check_output("rand_last_eof", WW'(got_eof[7]), WW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_5x5_gen.md
# window_5x5_gen

Streaming 5x5 neighbourhood generator that sits directly upstream of the 5x5 Gaussian operator in the sobel_v2 pipeline. It accepts one raster-order pixel per handshake and buffers four previous image lines in line memories. For every input pixel whose full 5x5 neighbourhood lies inside the frame, it emits one registered 200-bit window. The window packing is exactly the layout the Gaussian stage consumes.

## Interface
- IMG_WIDTH, 720: pixels per line (≥5).
- IMG_HEIGHT, 540: lines per frame (≥5).
- DWIDTH, 8: bits per pixel; window width is DWIDTH*25.
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all control state.
- in_valid  input  1  in_data holds a pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DWIDTH  pixel, raster order, top-left first.
- out_valid  output  1  out_window holds a valid window.
- out_ready  input  1  downstream accepts the window this cycle.
- out_window  output  DWIDTH*25  packed 5x5 window.
- out_eof  output  1  qualifies the last window of a frame (valid only with out_valid).

## Operation
- Input transfer occurs on an edge where in_valid && in_ready. Output transfer occurs on an edge where out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational. There is one output register and no skid buffer.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the next input pixel.
  - col increments on each input transfer.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next pixel is the first pixel of a new frame, and no frame marker is needed.
- Line buffers: four lines, each IMG_WIDTH x DWIDTH, addressed by col and shifted vertically on each input transfer.
  - Line 0 holds row-4, up to line 3 holding row-1.
  - At address col: line0 ← line1 ← line2 ← line3 ← in_data.
- The column column_in = {line0[col], line1[col], line2[col], line3[col], in_data} feeds a 5-column shift register. That register shifts left on each input transfer and is never cleared; entries left over from the previous row are overwritten before they are emitted.
- Emission condition: the transferred pixel has row ≥ 4 and col ≥ 4. This gives (IMG_HEIGHT-4)*(IMG_WIDTH-4) windows per frame.
- Packing: byte k = r*5 + c is at out_window[k*DWIDTH +: DWIDTH], for r, c in 0..4.
  - It holds pixel (row-4+r, col-4+c).
  - r=0 is the top (oldest) line; c=0 is the leftmost (oldest) column.
  - Byte 12 is the centre pixel (row-2, col-2).
- out_eof = 1 on the window emitted for pixel (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- Line buffer contents are not reset. Stale data is never emitted, because no window is produced before row 4 of the current frame.

## Timing
- Reset values: out_valid=0, out_eof=0, out_window=0, row=0, col=0, column shift register=0. in_ready=1 while reset is asserted and after release.
- Latency: a pixel transferred at edge N produces its window with out_valid=1 from just after edge N.
- A transfer of a non-emitting pixel while out_valid && out_ready clears out_valid. A transfer of an emitting pixel keeps out_valid at 1 with the new window.
- Simultaneous output transfer and emitting input transfer on the same edge: the window is replaced with no bubble. Full throughput is 1 pixel per clock.
- Stall (out_valid && !out_ready): in_ready=0, and out_window, out_eof and all counters hold. Input pixels are never dropped.
- in_valid gaps: counters and buffers hold, and the output sequence is identical to gapless input.
- Reset mid-frame: out_valid drops immediately (asynchronous). The next accepted pixel is treated as (0,0) of a new frame.

## Test plan
- Reset: assert reset mid-stream with out_valid=1 -> out_valid, out_eof and out_window go to 0 without a clock edge; in_ready=1.
- IMG_WIDTH=8, IMG_HEIGHT=6, pixel=row*16+col, in_valid=1, out_ready=1 -> exactly 8 windows.
  - First window (after pixel 0x44): byte0=0x00, byte12=0x22, byte24=0x44.
  - Last window: byte0=0x13, byte24=0x57, out_eof=1; out_eof=0 on the other 7.
- Backpressure, same image: hold out_ready=0 for 3 cycles at the first window -> in_ready=0 and the window stays stable. The sequence resumes, and the total is 8 windows with identical contents.
- Random in_valid gaps (~50%) with out_ready=1 -> window sequence is bit-identical to the gapless run.
- Two back-to-back frames (second frame pixel=0xFF-row*16-col) -> no window during rows 0-3 of frame 2. The first frame-2 window has byte0=0xFF and byte24=0xBB, with no frame-1 data mixed in.
- Reset after 20 pixels, then a full frame -> exactly 8 windows, matching the second test.
